hazard_control_unit: RTL



---
 rtl/hazard_control_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: forwarding selects, load-use / multi-cycle stalls and
// flush strobes for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Multi-cycle EX ops (mul/div) are sequenced by a RUN/MC_WAIT FSM and a down-counter.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush event counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; a multi-cycle op entering EX starts the wait
// MC_WAIT | multi-cycle op resident in EX; stall until cnt reaches 0
module hazard_control_unit #(
    parameter int MC_LATENCY = 4,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              mc_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    localparam int   CW       = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
    localparam logic MC_MULTI = (MC_LATENCY > 1);
    // MC_LATENCY-2 is only loaded when MC_LATENCY > 1, so clamp to keep it non-negative
    localparam int   CNT_LOAD = (MC_LATENCY > 2) ? (MC_LATENCY - 2) : 0;

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic lw_stall;
    logic mc_stall;

    // Forwarding select: MEM beats WB, x0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Next-state and counter for the multi-cycle sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (McStartE && MC_MULTI) begin
                    state_d = MC_WAIT;
                    cnt_d   = CW'(CNT_LOAD);
                end
            end
            MC_WAIT: begin
                // McStartE is ignored here: EX still holds the current op
                if (cnt_q != '0)
                    cnt_d = cnt_q - CW'(1);
                else
                    state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hazard detection and output equations; everything is forced quiet while rst is high
    always_comb begin
        lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mc_stall = ((state_q == RUN) && McStartE && MC_MULTI) ||
                   ((state_q == MC_WAIT) && (cnt_q != '0));

        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        mc_busy   = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            StallF    = lw_stall | mc_stall;
            StallD    = lw_stall | mc_stall;
            StallE    = mc_stall;
            FlushM    = mc_stall;
            // a multi-cycle stall masks both load-use and branch flushes
            FlushD    = PCSrcE & ~mc_stall;
            FlushE    = (lw_stall | PCSrcE) & ~mc_stall;
            mc_busy   = (state_q == MC_WAIT);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    // Saturating event counters for stall cycles and flush events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (StallF && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if ((FlushD || FlushE) && (flush_events_q != '1))
                flush_events_q <= flush_events_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule
